// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM with a handshaked duty triple that is applied only at period boundaries.
// Define RGB_PWM_GAMMA_EN to apply square-law gamma correction to duties as they are accepted.
module rgb_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 47
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    input  logic                duty_valid,
    output logic                duty_ready,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B,
    output logic                period_start
);
    localparam int PW = PRESCALE > 0 ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE);

    typedef logic [PWM_BITS-1:0] duty_t;

    function automatic duty_t shape(duty_t d);
`ifdef RGB_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] p;
        p = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        return p[2*PWM_BITS-1:PWM_BITS];
`else
        return d;
`endif
    endfunction

    logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
    duty_t               pwm_cnt_q, pwm_cnt_d;
    duty_t [2:0]         pend_q, pend_d;
    duty_t [2:0]         act_q, act_d;
    logic                pend_full_q, pend_full_d;
    logic [2:0]          rgb_q, rgb_d;
    logic                ps_q;
    logic                step, boundary, accept;

    always_comb begin
        step        = pre_cnt_q == PRE_MAX;
        boundary    = step && (pwm_cnt_q == '1);
        accept      = duty_valid && !pend_full_q;
        pre_cnt_d   = step ? '0 : pre_cnt_q + PW'(1);
        pwm_cnt_d   = step ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        pend_d      = accept ? {shape(duty_b), shape(duty_g), shape(duty_r)} : pend_q;
        // an accept coinciding with an empty-pending boundary only fills pending
        pend_full_d = accept ? 1'b1 : (boundary ? 1'b0 : pend_full_q);
        act_d       = (boundary && pend_full_q) ? pend_q : act_q;
        rgb_d       = {pwm_cnt_q < act_q[2], pwm_cnt_q < act_q[1], pwm_cnt_q < act_q[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            pend_q      <= '0;
            act_q       <= '0;
            pend_full_q <= 1'b0;
            rgb_q       <= '0;
            ps_q        <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            pend_full_q <= pend_full_d;
            rgb_q       <= rgb_d;
            ps_q        <= boundary;
        end
    end

    assign duty_ready   = !pend_full_q;
    assign RGB_R        = rgb_q[0];
    assign RGB_G        = rgb_q[1];
    assign RGB_B        = rgb_q[2];
    assign period_start = ps_q;
endmodule

// File: doc/rgb_pwm_driver.md
# rgb_pwm_driver

Downstream stage for the colour sequencer: converts per-channel duty values into glitch-free PWM on the three RGB LED pins, so colours can be blended and dimmed rather than only switched on and off. It accepts a new {R,G,B} duty triple through a valid/ready handshake. The triple is held in a pending register and applied only at a PWM period boundary, so no channel ever shows a truncated or doubled pulse.

## Interface
- PWM_BITS, 8, duty and PWM counter width; one period has 2^PWM_BITS steps
- PRESCALE, 47, clocks per PWM step minus one; the default gives about 976.6 Hz at 12 MHz
- clk  input  1  system clock (12 MHz on board)
- rst_n  input  1  asynchronous, active-low reset
- duty_r  input  PWM_BITS  red duty, 0 means off
- duty_g  input  PWM_BITS  green duty
- duty_b  input  PWM_BITS  blue duty
- duty_valid  input  1  duty triple is presented
- duty_ready  output  1  pending slot is free
- RGB_R  output  1  red PWM, 1 = LED on
- RGB_G  output  1  green PWM, 1 = LED on
- RGB_B  output  1  blue PWM, 1 = LED on
- period_start  output  1  one-cycle pulse when a new PWM period begins

## Operation
- Prescaler: `pre_cnt` counts 0..PRESCALE and wraps. `step` is asserted in the cycle where pre_cnt == PRESCALE.
- PWM counter: `pwm_cnt` (PWM_BITS wide) increments on `step` and wraps from 2^PWM_BITS-1 to 0.
- Boundary: the cycle where `step` is high and pwm_cnt == 2^PWM_BITS-1.
- Registers:
  - Pending register holds three duties plus a `pend_full` flag.
  - Active register holds three duties.
- Handshake:
  - duty_ready = !pend_full.
  - Transfer when duty_valid && duty_ready. The triple is captured into pending and pend_full is set.
  - duty_* must be held stable while duty_valid is high and ready is low.
  - Dropping valid before acceptance is legal; nothing is captured.
- At the boundary:
  - If pend_full, active <= pending and pend_full is cleared.
  - Otherwise active is unchanged.
- Same-cycle accept and boundary with pend_full low: the new triple goes to pending only. It is applied at the following boundary.
- A new transfer cannot overwrite pending, because ready is low while it is full.
- Output compare: RGB_x <= (pwm_cnt < active_x), registered every clock.
  - Duty 0 gives constantly 0.
  - Duty 2^PWM_BITS-1 gives high for 255 of 256 steps; full-on is not reachable by design.
- period_start is registered and is high in the cycle after the boundary.

## Timing
- Reset values:
  - pre_cnt = 0, pwm_cnt = 0, active = 0, pending = 0, pend_full = 0.
  - RGB_R/G/B = 0, period_start = 0, duty_ready = 1.
- Reset is asynchronous and takes effect without a clock edge. Deassertion is used synchronously by the upstream reset synchroniser.
- Reset mid-period:
  - Outputs drop to 0 immediately.
  - A pending triple is discarded.
  - After release, the first period starts from pwm_cnt = 0 with zero duties.
- Period length: (PRESCALE+1)·2^PWM_BITS clocks. The default is 12 288.
- Step length: PRESCALE+1 clocks. A channel with duty D is high for D·(PRESCALE+1) clocks per period.
- Output latency:
  - RGB_x lags pwm_cnt by one clock.
  - A duty accepted at cycle t appears at the first boundary after t, plus 1 clock.
  - Worst-case latency is one period plus 1 clock.
- duty_ready falls in the cycle after acceptance. It rises in the cycle after the boundary that consumes pending.

## Configuration
- Macro RGB_PWM_GAMMA_EN.
- Defined: the captured duty is gamma-corrected at acceptance.
  - stored = (D·D) >> PWM_BITS, using a 2·PWM_BITS-bit product truncated to PWM_BITS.
  - Example: 128→64, 255→254, 15→0.
  - Correction is applied per channel in the accept cycle; handshake timing is unchanged.
- Undefined: the duty is stored linearly (stored = D) and the multiplier is absent.

## Test plan
- Reset, then accept (255,0,128) with defaults: duty_ready drops for exactly the remainder of the first period. In the next period RGB_R is high for 12 240 clocks, RGB_G stays 0, and RGB_B is high for 6 144 clocks.
- Present a valid triple while pend_full = 1: duty_ready = 0 and the triple is not captured until after the boundary. A second triple accepted mid-period is not visible until the following period.
- Assert duty_valid in the exact boundary cycle with pending empty: the active duties are unchanged for that period. The new duties appear one period later.
- Assert rst_n low mid-period with RGB_R high and pend_full = 1: RGB_R goes to 0 asynchronously and duty_ready goes to 1. After release, all outputs stay 0 for a full 12 288-clock period.
- With RGB_PWM_GAMMA_EN defined, accept (128,255,15): high times per period are 64·48, 254·48 and 0 clocks. Without the macro they are 128·48, 255·48 and 15·48 clocks.
- With PRESCALE = 0 and PWM_BITS = 4: period_start pulses every 16 clocks. Duty 1 gives a 1-clock high pulse aligned one clock after period_start.
